// File: rtl/ram_8x8_pkg.sv
// Shared sizing constants and word type for the 8x8 flip-flop RAM.
package ram_8x8_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/ram_8x8_word.sv
// One storage word: a register with synchronous clear and a load enable.
module ram_8x8_word
    import ram_8x8_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear wins over load so a write issued during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ram_8x8.sv
// 8-word flip-flop RAM: one-hot write decode, 8:1 read mux, registered Q.
// A read returns the word as stored before the edge; Q holds during writes.
module ram_8x8 #(
    parameter int DATA_W = ram_8x8_pkg::DATA_W,
    parameter int ADDR_W = ram_8x8_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic              rst
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]             wr_sel;
    logic [DEPTH-1:0][DATA_W-1:0] words;
    logic [DATA_W-1:0]            rd_data;

    // One-hot write select; all zero when not writing.
    always_comb begin
        wr_sel = '0;
        if (we) begin
            wr_sel[addr] = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            ram_8x8_word #(
                .W (DATA_W)
            ) u_word (
                .clk (clk),
                .rst (rst),
                .we  (wr_sel[gi]),
                .d   (D),
                .q   (words[gi])
            );
        end
    endgenerate

    // Read mux looks at the pre-edge contents, so no write-through exists.
    always_comb begin
        rd_data = words[addr];
    end

    // Output register: cleared by reset, loaded only on read cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= '0;
        end else if (!we) begin
            Q <= rd_data;
        end
    end

endmodule

// File: tb/tb_ram_8x8.sv
// Scoreboard bench for ram_8x8: the driver queues the expected Q for each
// checked cycle, the monitor pops and compares on the following falling edge.
module tb_ram_8x8;

    logic       clk;
    logic [7:0] D;
    logic [7:0] Q;
    logic [2:0] addr;
    logic       we;
    logic       rst;

    logic       chk_tag;
    logic [7:0] exp_q[$];
    string      exp_name[$];
    int         errors;
    int         checks;

    ram_8x8 dut (
        .clk  (clk),
        .D    (D),
        .Q    (Q),
        .addr (addr),
        .we   (we),
        .rst  (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus; when chk is set, Q after the coming
    // rising edge must equal exp.
    task automatic op(input logic r, input logic w, input logic [2:0] a,
                      input logic [7:0] d, input logic chk,
                      input logic [7:0] exp, input string name);
        @(negedge clk);
        rst  = r;
        we   = w;
        addr = a;
        D    = d;
        chk_tag = chk;
        if (chk) begin
            exp_q.push_back(exp);
            exp_name.push_back(name);
        end
    endtask

    // Monitor: latch whether this edge is a checked one, compare half a cycle later.
    initial begin
        logic       v;
        logic [7:0] e;
        string      n;
        forever begin
            @(posedge clk);
            v = chk_tag;
            @(negedge clk);
            if (v) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow: Q=%02h with no expectation", Q);
                end else begin
                    e = exp_q.pop_front();
                    n = exp_name.pop_front();
                    if (Q !== e) begin
                        errors++;
                        $display("FAIL %s: Q=%02h expected %02h", n, Q, e);
                    end
                end
            end
        end
    end

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        we      = 1'b0;
        addr    = 3'd0;
        D       = 8'h00;
        chk_tag = 1'b0;

        // Reset state
        op(1, 0, 0, 8'h00, 1, 8'h00, "reset_q");

        // All-ones fill; Q must not follow the write data
        for (int k = 0; k < 8; k++)
            op(0, 1, 3'(k), 8'hFF, 1, 8'h00, "write_hold_ff");
        for (int k = 0; k < 8; k++)
            op(0, 0, 3'(k), 8'h00, 1, 8'hFF, "read_ff");

        // Distinct pattern per word, read back in reverse
        for (int k = 0; k < 8; k++)
            op(0, 1, 3'(k), 8'(k * 8'h11), 0, 8'h00, "");
        for (int k = 7; k >= 0; k--)
            op(0, 0, 3'(k), 8'h00, 1, 8'(k * 8'h11), "read_pattern");

        // Write then immediate read, then a write that must not disturb Q
        op(0, 1, 3, 8'hA5, 1, 8'h00, "write_a5_hold");
        op(0, 0, 3, 8'h00, 1, 8'hA5, "read_after_write");
        op(0, 1, 3, 8'h5A, 1, 8'hA5, "write_5a_hold");
        op(0, 1, 3, 8'h5A, 1, 8'hA5, "write_5a_hold2");
        op(0, 0, 3, 8'h00, 1, 8'h5A, "read_5a");

        // Repeated reads with no writes stay stable
        op(0, 0, 3, 8'h00, 1, 8'h5A, "stable_read1");
        op(0, 0, 3, 8'h00, 1, 8'h5A, "stable_read2");
        op(0, 0, 3, 8'h00, 1, 8'h5A, "stable_read3");

        // Fill with ones, single-cycle reset, everything reads back zero
        for (int k = 0; k < 8; k++)
            op(0, 1, 3'(k), 8'hFF, 0, 8'h00, "");
        op(0, 0, 5, 8'h00, 1, 8'hFF, "pre_reset_read");
        op(1, 0, 5, 8'h00, 1, 8'h00, "mid_reset_q");
        for (int k = 0; k < 8; k++)
            op(0, 0, 3'(k), 8'h00, 1, 8'h00, "read_after_reset");

        // Write during reset is discarded; normal writes resume afterwards
        op(0, 1, 6, 8'h77, 0, 8'h00, "");
        op(0, 0, 6, 8'h00, 1, 8'h77, "read_77");
        op(1, 1, 2, 8'h3C, 1, 8'h00, "reset_with_write_q");
        op(0, 0, 2, 8'h00, 1, 8'h00, "discarded_write");
        op(0, 0, 6, 8'h00, 1, 8'h00, "reset_cleared_6");
        op(0, 1, 2, 8'h3C, 1, 8'h00, "resume_write_hold");
        op(0, 0, 2, 8'h00, 1, 8'h3C, "resume_read");

        // Flush the last check, then confirm nothing was left unchecked
        op(0, 0, 0, 8'h00, 0, 8'h00, "");
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_8x8.md
RAM_8X8 -- requirements
Module: ram_8x8

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset named rst.
REQ-002 Parameter DATA_W, default 8, SHALL set the word width in bits; only 8 is required to be supported.
REQ-003 Parameter ADDR_W, default 3, SHALL set the address width; depth is 2**ADDR_W = 8 words; only 3 is required to be supported.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-006 Port D, input, DATA_W bits, SHALL carry write data.
REQ-007 Port Q, output, DATA_W bits, SHALL carry registered read data.
REQ-008 Port addr, input, ADDR_W bits, SHALL select the word for both read and write.
REQ-009 Port we, input, 1 bit, SHALL select write (1) or read (0).
REQ-010 Port order SHALL be clk, D, Q, addr, we, rst, so positional instantiation of the first five ports is valid.

Function
REQ-011 Storage SHALL be 8 words x 8 bits of flip-flops, 64 bits total.
REQ-012 When rst=0 and we=1 at a rising clk edge, word[addr] SHALL take the value of D; all other words SHALL hold.
REQ-013 When rst=0 and we=0 at a rising clk edge, Q SHALL take the value of word[addr] sampled at that edge; read latency is 1 cycle.
REQ-014 While we=1, Q SHALL hold its previous value; there is no write-through.
REQ-015 When no write occurs, storage SHALL hold indefinitely.
REQ-016 Back-to-back writes to different addresses on consecutive cycles SHALL each complete in one cycle.
REQ-017 Back-to-back reads on consecutive cycles SHALL each return word[addr] of the preceding edge.
REQ-018 A read in the cycle immediately after a write to the same address SHALL return the new data.
REQ-019 All 8 addresses (0-7) SHALL be valid; no out-of-range condition exists.
REQ-020 X or Z on we SHALL NOT be required to have defined behaviour; the bench SHALL drive we and addr to known values after reset.

Reset
REQ-021 When rst=1 at a rising clk edge, all 64 storage bits SHALL become 0 and Q SHALL become 8'h00.
REQ-022 rst SHALL take priority over we; a write asserted with rst=1 SHALL be discarded.
REQ-023 Reset asserted mid-sequence SHALL clear state within that single edge; operation SHALL resume on the next edge after rst=0.

Structure
REQ-024 A shared package ram_8x8_pkg SHALL hold DATA_W=8, ADDR_W=3, DEPTH=8 and a word typedef of DATA_W bits.
REQ-025 One sub-module, ram_8x8_word, SHALL implement one 8-bit register with a synchronous reset and a write-enable input.
REQ-026 The top level SHALL instantiate 8 ram_8x8_word instances, a 3-to-8 one-hot write decoder gated by we, an 8:1 read mux and the Q register.

Verification
REQ-027 Write each address 0-7 with D=8'hFF (we=1, one per cycle), then read 0-7 (we=0) -> Q=8'hFF one cycle after each address.
REQ-028 Write address k with D=k*8'h11 for k=0..7, then read in reverse order 7..0 -> Q=k*8'h11 with 1-cycle latency; no aliasing between words.
REQ-029 Write addr 3 = 8'hA5, then read addr 3 on the next cycle -> Q=8'hA5; then write addr 3 = 8'h5A with Q held -> Q stays 8'hA5 until the next read.
REQ-030 Fill all words with 8'hFF, assert rst for 1 cycle, then read all words -> Q=8'h00 immediately after reset and every word reads 8'h00.
REQ-031 Assert rst=1 and we=1 with addr=2, D=8'h3C together, then read addr 2 -> 8'h00, confirming the write was discarded.
REQ-032 Read the same address on consecutive cycles with no writes -> Q is stable and identical.
